// File: rtl/pause_pkg.sv
// Shared types and helpers for the CPU pause/clock-enable path.
package pause_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } pause_state_t;

  // A divide-by-2 still needs one counter bit.
  function automatic int ctr_width(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/cen_divider.sv
// Free-running divide-by-DIV counter; slot marks the last count of each period.
module cen_divider
  import pause_pkg::*;
#(
  parameter int DIV = 8
) (
  input  logic clk_sys,
  input  logic reset,
  output logic slot
);

  localparam int            W    = ctr_width(DIV);
  localparam logic [W-1:0]  LAST = W'(DIV - 1);

  logic [W-1:0] ctr_q;
  logic [W-1:0] ctr_d;

  always_comb begin
    ctr_d = (ctr_q == LAST) ? '0 : ctr_q + W'(1);
  end

  // Never gated: resume must keep phase with the video timing.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      ctr_q <= '0;
    end else begin
      ctr_q <= ctr_d;
    end
  end

  assign slot = (ctr_q == LAST);

endmodule

// File: rtl/pause_cen_gate.sv
// CPU clock-enable gate: halts the CPU at an opcode fetch when pause is
// requested, forcing the halt after DRAIN_MAX enables without a fetch.
//
//   state | meaning
//   RUN   | enables issued every slot
//   DRAIN | pause requested, issuing enables until an opcode fetch
//   HALT  | no enables, CPU frozen (paused = 1)
module pause_cen_gate
  import pause_pkg::*;
#(
  parameter int DIV       = 8,
  parameter int DRAIN_MAX = 16
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic pause_cpu,
  input  logic cpu_sync,
  output logic cpu_cen,
  output logic paused,
  output logic forced
);

  localparam logic [7:0] DMAX = 8'(DRAIN_MAX);

  logic         slot;
  pause_state_t state_q, state_d;
  logic [7:0]   dcnt_q, dcnt_d;
  logic         cen_q, cen_d;
  logic         paused_q, paused_d;
  logic         forced_q, forced_d;

  cen_divider #(
    .DIV (DIV)
  ) u_div (
    .clk_sys (clk_sys),
    .reset   (reset),
    .slot    (slot)
  );

  always_comb begin
    state_d  = state_q;
    dcnt_d   = dcnt_q;
    cen_d    = 1'b0;
    forced_d = forced_q;
    case (state_q)
      RUN: begin
        cen_d = slot;
        if (pause_cpu) begin
          state_d = DRAIN;
          dcnt_d  = '0;
        end
      end
      DRAIN: begin
        // A dropped pause wins over the slot evaluation, so no enable is lost.
        if (!pause_cpu) begin
          state_d = RUN;
          cen_d   = slot;
        end else if (slot) begin
          if (cpu_sync) begin
            state_d  = HALT;
            forced_d = 1'b0;
          end else if (dcnt_q == DMAX) begin
            state_d  = HALT;
            forced_d = 1'b1;
          end else begin
            cen_d  = 1'b1;
            dcnt_d = dcnt_q + 8'd1;
          end
        end
      end
      HALT: begin
        if (!pause_cpu) begin
          state_d  = RUN;
          forced_d = 1'b0;
        end
      end
      default: begin
        state_d  = RUN;
        forced_d = 1'b0;
      end
    endcase
    paused_d = (state_d == HALT);
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q  <= RUN;
      dcnt_q   <= '0;
      cen_q    <= 1'b0;
      paused_q <= 1'b0;
      forced_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dcnt_q   <= dcnt_d;
      cen_q    <= cen_d;
      paused_q <= paused_d;
      forced_q <= forced_d;
    end
  end

  assign cpu_cen = cen_q;
  assign paused  = paused_q;
  assign forced  = forced_q;

endmodule

// File: tb/tb_pause_cen_gate.sv
// Directed bench for pause_cen_gate at DIV = 8, DRAIN_MAX = 16.
module tb_pause_cen_gate;

  localparam int DIV       = 8;
  localparam int DRAIN_MAX = 16;

  logic clk_sys   = 1'b0;
  logic reset     = 1'b1;
  logic pause_cpu = 1'b0;
  logic cpu_sync  = 1'b0;
  logic cpu_cen;
  logic paused;
  logic forced;

  int n_chk  = 0;
  int n_pass = 0;
  int e;

  pause_cen_gate #(
    .DIV       (DIV),
    .DRAIN_MAX (DRAIN_MAX)
  ) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .pause_cpu (pause_cpu),
    .cpu_sync  (cpu_sync),
    .cpu_cen   (cpu_cen),
    .paused    (paused),
    .forced    (forced)
  );

  always #5 clk_sys = ~clk_sys;

  // Edges since reset release; after edge k the divider holds k mod DIV.
  always @(posedge clk_sys or posedge reset) begin
    if (reset) e <= 0;
    else       e <= e + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d at edge %0d", tag, obs, exp, e);
  endtask

  task automatic tick_chk(input logic ecen, input logic epaused, input logic eforced);
    @(negedge clk_sys);
    chk("cpu_cen", {31'd0, cpu_cen}, {31'd0, ecen});
    chk("paused",  {31'd0, paused},  {31'd0, epaused});
    chk("forced",  {31'd0, forced},  {31'd0, eforced});
  endtask

  // Normal running: a pulse whenever the divider has just wrapped.
  task automatic run_to(input int last);
    int n;
    while (e < last) begin
      n = e + 1;
      tick_chk(n % DIV == 0, 1'b0, 1'b0);
    end
  endtask

  // Pause requested at ctr = 0 with no opcode fetch: DRAIN_MAX enables, then forced halt.
  task automatic forced_drain();
    int s, halt_at, n, cnt;
    s       = e;
    halt_at = s + DIV * (DRAIN_MAX + 1);
    cnt     = 0;
    pause_cpu = 1'b1;
    cpu_sync  = 1'b0;
    while (e < halt_at) begin
      n = e + 1;
      tick_chk((n % DIV == 0) && (n < halt_at), n >= halt_at, n >= halt_at);
      if (cpu_cen === 1'b1) cnt++;
    end
    chk("drain_enable_count", cnt, DRAIN_MAX);
  endtask

  initial begin
    int n;
    @(negedge clk_sys);
    chk("reset_cpu_cen", {31'd0, cpu_cen}, 32'd0);
    chk("reset_paused",  {31'd0, paused},  32'd0);
    chk("reset_forced",  {31'd0, forced},  32'd0);
    @(negedge clk_sys);
    reset = 1'b0;

    // First enable 8 cycles after release, then every 8.
    run_to(24);

    // Clean halt: fetch seen at the third slot after the request.
    pause_cpu = 1'b1;
    while (e < 48) begin
      n = e + 1;
      tick_chk(n == 32 || n == 40, n >= 48, 1'b0);
      if (e == 47) cpu_sync = 1'b1;
    end
    cpu_sync = 1'b0;
    repeat (1000) tick_chk(1'b0, 1'b1, 1'b0);

    // Resume mid-period (ctr = 3); first enable at the next wrap.
    while (e < 1051) tick_chk(1'b0, 1'b1, 1'b0);
    pause_cpu = 1'b0;
    run_to(1064);

    forced_drain();

    // Drop pause with forced set; it must clear alongside paused.
    while (e < 1205) tick_chk(1'b0, 1'b1, 1'b1);
    pause_cpu = 1'b0;
    run_to(1216);

    // Three-cycle pause blip inside one period: nothing missed, never paused.
    pause_cpu = 1'b1;
    run_to(1219);
    pause_cpu = 1'b0;
    run_to(1232);

    // Async reset while force-halted.
    forced_drain();
    tick_chk(1'b0, 1'b1, 1'b1);
    tick_chk(1'b0, 1'b1, 1'b1);
    pause_cpu = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("async_rst_cpu_cen", {31'd0, cpu_cen}, 32'd0);
    chk("async_rst_paused",  {31'd0, paused},  32'd0);
    chk("async_rst_forced",  {31'd0, forced},  32'd0);
    tick_chk(1'b0, 1'b0, 1'b0);
    tick_chk(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    run_to(24);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
